// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and a variable-latency data memory.
// Handles B/H/W accesses with extension, byte lanes, misalignment and a WAIT timeout.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state, w_state_d;
    logic                  r_we, w_we_d;
    logic [2:0]            r_funct3, w_funct3_d;
    logic [1:0]            r_addr_lo, w_addr_lo_d;
    logic [CntW-1:0]       r_cnt, w_cnt_d, w_cnt_inc;
    logic                  r_mem_req, w_mem_req_d;
    logic                  r_mem_we, w_mem_we_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_d;
    logic [3:0]            r_mem_be, w_mem_be_d;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_d;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_rsp_err, w_rsp_err_d;

    logic                  w_misaligned;
    logic [3:0]            w_st_be;
    logic [DATA_WIDTH-1:0] w_st_wdata;
    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic [DATA_WIDTH-1:0] w_ld_data;

    // Undefined width codes fall into the misaligned path so they never reach memory.
    always_comb begin
        unique case (req_funct3_i)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = req_addr_i[0];
            3'b010:         w_misaligned = (req_addr_i[1:0] != 2'b00);
            default:        w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = req_wdata_i;
        if (req_we_i) begin
            unique case (req_funct3_i[1:0])
                2'b00: begin
                    w_st_be    = 4'b0001 << req_addr_i[1:0];
                    w_st_wdata = {4{req_wdata_i[7:0]}};
                end
                2'b01: begin
                    w_st_be    = 4'b0011 << req_addr_i[1:0];
                    w_st_wdata = {2{req_wdata_i[15:0]}};
                end
                default: begin
                    w_st_be    = 4'b1111;
                    w_st_wdata = req_wdata_i;
                end
            endcase
        end else begin
            w_st_wdata = '0;
        end
    end

    assign w_ld_byte = mem_rdata_i[{r_addr_lo, 3'b000} +: 8];
    assign w_ld_half = mem_rdata_i[{r_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        unique case (r_funct3)
            3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_ld_byte};
            3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_ld_half};
            default: w_ld_data = mem_rdata_i;
        endcase
    end

    assign w_cnt_inc = r_cnt + CntW'(1);

    always_comb begin
        w_state_d     = r_state;
        w_we_d        = r_we;
        w_funct3_d    = r_funct3;
        w_addr_lo_d   = r_addr_lo;
        w_cnt_d       = r_cnt;
        w_mem_req_d   = 1'b0;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_be_d    = r_mem_be;
        w_mem_wdata_d = r_mem_wdata;
        w_rsp_rdata_d = r_rsp_rdata;
        w_rsp_err_d   = r_rsp_err;
        unique case (r_state)
            StIdle: begin
                if (req_valid_i) begin
                    w_we_d      = req_we_i;
                    w_funct3_d  = req_funct3_i;
                    w_addr_lo_d = req_addr_i[1:0];
                    w_cnt_d     = '0;
                    if (w_misaligned) begin
                        w_state_d     = StResp;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = '0;
                    end else begin
                        w_state_d     = StWait;
                        w_mem_req_d   = 1'b1;
                        w_mem_we_d    = req_we_i;
                        w_mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        w_mem_be_d    = w_st_be;
                        w_mem_wdata_d = w_st_wdata;
                    end
                end
            end
            StWait: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mem_rvalid_i) begin
                    w_state_d     = StResp;
                    w_rsp_err_d   = 1'b0;
                    w_rsp_rdata_d = r_we ? '0 : w_ld_data;
                    w_cnt_d       = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == CntW'(TIMEOUT_CYCLES))) begin
                    w_state_d     = StResp;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_rdata_d = '0;
                    w_cnt_d       = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    w_state_d     = StIdle;
                    w_rsp_err_d   = 1'b0;
                    w_rsp_rdata_d = '0;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_we        <= w_we_d;
            r_funct3    <= w_funct3_d;
            r_addr_lo   <= w_addr_lo_d;
            r_cnt       <= w_cnt_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_be    <= w_mem_be_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rsp_err   <= w_rsp_err_d;
        end
    end

    assign req_ready_o = (r_state == StIdle);
    assign rsp_valid_o = (r_state == StResp);
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change and outputs are sampled on the falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata)
    );

    // Presents one request for one cycle; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if ({mem_req, mem_we, mem_be} !== 6'b0) begin n_err++; $display("FAIL rst_mem_ctl got %b want 000000", {mem_req, mem_we, mem_be}); end
        n_vec++; if ({mem_addr, mem_wdata, rsp_rdata, rsp_err} !== 97'b0) begin n_err++; $display("FAIL rst_data got %h want 0", {mem_addr, mem_wdata, rsp_rdata, rsp_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw_latency();
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL lw_mem_req got %b want 1", mem_req); end
        n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL lw_mem_addr got %h want 00000100", mem_addr); end
        n_vec++; if ({mem_we, mem_be} !== 5'b0_1111) begin n_err++; $display("FAIL lw_we_be got %b want 01111", {mem_we, mem_be}); end
        @(negedge clk);
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lw_req_pulse got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL lw_addr_hold got %h want 00000100", mem_addr); end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_early_rsp got %b want 0", rsp_valid); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL lw_rsp_valid_c4 got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rdata got %h want deadbeef", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL lw_err got %b want 0", rsp_err); end
        @(negedge clk);
        n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL lw_back_idle got %b want 10", {req_ready, rsp_valid}); end
    endtask

    // Zero-wait memory: completion in the same cycle as the request strobe.
    task automatic test_byte_half_loads();
        logic [2:0]  f3_tab[4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addr_tab[4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exp_tab[4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3_tab[i], addr_tab[i], 32'h0);
            n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL ld%0d_mem_req got %b want 1", i, mem_req); end
            n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL ld%0d_mem_addr got %h want 00000100", i, mem_addr); end
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h80FF_1234;
            @(negedge clk);
            mem_rvalid = 1'b0;
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL ld%0d_rsp_valid got %b want 1", i, rsp_valid); end
            n_vec++; if (rsp_rdata !== exp_tab[i]) begin n_err++; $display("FAIL ld%0d_rdata got %h want %h", i, rsp_rdata, exp_tab[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_store_half();
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        n_vec++; if (mem_addr !== 32'h200) begin n_err++; $display("FAIL sh_mem_addr got %h want 00000200", mem_addr); end
        n_vec++; if (mem_be !== 4'b1100) begin n_err++; $display("FAIL sh_be got %b want 1100", mem_be); end
        n_vec++; if (mem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata got %h want abcdabcd", mem_wdata); end
        n_vec++; if ({mem_req, mem_we} !== 2'b11) begin n_err++; $display("FAIL sh_req_we got %b want 11", {mem_req, mem_we}); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_err++; $display("FAIL sh_rsp got %b want 10", {rsp_valid, rsp_err}); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL sh_rdata got %h want 00000000", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        logic [2:0] f3_tab[3] = '{3'b010, 3'b001, 3'b011};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, f3_tab[i], 32'h0000_0101, 32'h0);
            n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mis%0d_mem_req got %b want 0", i, mem_req); end
            n_vec++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_err++; $display("FAIL mis%0d_rsp got %b want 11", i, {rsp_valid, rsp_err}); end
            n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL mis%0d_rdata got %h want 0", i, rsp_rdata); end
            @(negedge clk);
            n_vec++; if ({mem_req, req_ready} !== 2'b01) begin n_err++; $display("FAIL mis%0d_after got %b want 01", i, {mem_req, req_ready}); end
        end
    endtask

    task automatic test_timeout();
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL to_wait_c%0d got %b want 0", c, rsp_valid); end
            @(negedge clk);
        end
        n_vec++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_err++; $display("FAIL to_rsp got %b want 11", {rsp_valid, rsp_err}); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL to_rdata got %h want 0", rsp_rdata); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL to_late_resp got %b/%h want 11/00000000", {rsp_valid, rsp_err}, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin n_err++; $display("FAIL to_late_idle got %b want 100", {req_ready, rsp_valid, mem_req}); end
        // Completion in the 16th WAIT cycle must beat the timeout.
        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        repeat (15) @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL to_next_c16 got %b want 0", rsp_valid); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_err++; $display("FAIL to_next_rsp got %b want 10", {rsp_valid, rsp_err}); end
        n_vec++; if (rsp_rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL to_next_rdata got %h want cafef00d", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0000_0108, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA_55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int c = 0; c < 5; c++) begin
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c%0d got %b want 1", c, rsp_valid); end
            n_vec++; if (rsp_rdata !== 32'h55AA_55AA) begin n_err++; $display("FAIL bp_rdata_c%0d got %h want 55aa55aa", c, rsp_rdata); end
            n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c%0d got %b want 0", c, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release got %b want 10", {req_ready, rsp_valid}); end
    endtask

    task automatic test_reset_mid_wait();
        issue(1'b0, 3'b010, 32'h0000_010C, 32'h0);
        @(negedge clk);
        n_vec++; if ({mem_req, mem_addr} !== {1'b0, 32'h10C}) begin n_err++; $display("FAIL rw_wait got %h want 0000010c", mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL rw_async_hs got %b want 10", {req_ready, rsp_valid}); end
        n_vec++; if ({mem_addr, mem_be, mem_we, mem_req} !== 38'b0) begin n_err++; $display("FAIL rw_async_mem got %h want 0", {mem_addr, mem_be, mem_we, mem_req}); end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({req_ready, rsp_valid, mem_req} !== 3'b100) begin n_err++; $display("FAIL rw_late_cpl got %b want 100", {req_ready, rsp_valid, mem_req}); end
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A);
        n_vec++; if ({mem_be, mem_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin n_err++; $display("FAIL rw_sb got %b/%h want 0010/5a5a5a5a", mem_be, mem_wdata); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rw_sb_addr got %h want 00000000", mem_addr); end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        n_vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL rw_sb_rsp got %b/%h want 10/00000000", {rsp_valid, rsp_err}, rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_lw_latency();
        test_byte_half_loads();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store unit between the core datapath and a variable-latency data memory.
- Generalises the single-cycle word-only data memory path: byte, halfword and word accesses; sign and zero extension; byte enables; misalignment detection.
- Valid/ready handshakes on both the core and memory sides, plus a bounded-wait timeout.
- Sits after the ALU: address = ALUResult, store data = RD2; the load result feeds the writeback mux.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  core request valid
- req_ready_o  output  1  unit can accept a request
- req_we_i  input  1  1 = store, 0 = load
- req_funct3_i  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  DATA_WIDTH  store data, LSB-aligned
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  core accepts the response
- rsp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores
- rsp_err_o  output  1  misaligned access or timeout
- mem_req_o  output  1  one-cycle memory request strobe
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 00
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  DATA_WIDTH  lane-replicated store data
- mem_rvalid_i  input  1  memory completion; load data valid or store acknowledged
- mem_rdata_i  input  DATA_WIDTH  memory read word

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: state = IDLE; req_ready_o = 1; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0; mem_req_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_be_o = 0; mem_wdata_o = 0; timeout counter = 0.
- Reset mid-operation aborts the transaction immediately. Any memory completion arriving after reset is ignored.
- States are IDLE, WAIT and RESP. req_ready_o = 1 only in IDLE.
- IDLE: a request is accepted on req_valid_i && req_ready_o; addr, funct3, we and wdata are latched.
  - Misaligned requests skip memory and go to RESP next cycle with err = 1. Misaligned means H/HU with addr[0] = 1, or W with addr[1:0] != 0. Undefined funct3 is treated as misaligned.
  - Aligned requests go to WAIT.
- First cycle of WAIT: mem_req_o = 1 for exactly one cycle, with mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o registered. These signals hold stable for the whole of WAIT.
- mem_rvalid_i is sampled in every WAIT cycle, including the request cycle (zero-wait memory is allowed). On completion the unit goes to RESP; for loads it captures the extended data.
- Timeout: the counter increments on each WAIT cycle without completion. When the counter reaches TIMEOUT_CYCLES, the unit goes to RESP with err = 1 and rdata = 0. The counter clears on leaving WAIT.
- mem_rvalid_i is ignored in IDLE and RESP, so a late completion after a timeout is dropped.
- RESP: rsp_valid_o = 1; rdata and err are held stable until rsp_ready_i. On the handshake the unit returns to IDLE, with req_ready_o = 1 in the next cycle. Minimum request-to-request spacing is 3 cycles.
- Store lanes:
  - SB: wdata = {4{b}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, be = 0011 << addr[1:0].
  - SW: be = 1111.
- Loads: select the byte at addr[1:0] or the halfword at addr[1]. B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Loads drive be = 1111 and we = 0.

Test Plan:
- LW at addr 0x100; memory returns 0xDEADBEEF 2 cycles after mem_req_o -> mem_addr_o = 0x100, be = 1111; rsp_rdata_o = 0xDEADBEEF, err = 0; 4 cycles from accept to rsp_valid_o.
- LB and LBU at 0x103 with mem_rdata = 0x80FF1234, zero-wait memory -> LB gives 0xFFFFFF80, LBU gives 0x00000080; in both cases mem_rvalid_i in the same cycle as mem_req_o is accepted.
- SH at 0x202 with wdata 0x0000ABCD -> mem_addr_o = 0x200, be = 1100, mem_wdata_o = 0xABCDABCD, mem_we_o = 1; the response carries rdata = 0 and err = 0.
- LW at 0x101 -> mem_req_o never asserts; rsp_err_o = 1 in the cycle after acceptance; LH at 0x101 behaves the same.
- Timeout: TIMEOUT_CYCLES = 16, memory never responds -> err = 1 and rdata = 0 after 16 WAIT cycles. A mem_rvalid_i pulse then arriving in RESP and in IDLE is ignored, and the next LW completes normally.
- Backpressure and reset:
  - Hold rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stay stable and req_ready_o stays 0.
  - Assert rst_ni = 0 during WAIT -> all outputs return to reset values immediately, without waiting for a clock edge, and a subsequent request works.
